// File: rtl/layer_mac_pkg.sv
// Shared types and helpers for the layer MAC sequencer: state encoding, table
// addressing and the signed saturation used when LAYER_MAC_SATURATE_EN is defined.
package layer_mac_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        BIAS,
        DONE
    } state_t;

    // Entry k of node's row; k == num_in selects the bias.
    function automatic int addr(input int node, input int k, input int num_in);
        return node * (num_in + 1) + k;
    endfunction

    // Clamp a 2*DW two's complement value into the DW signed range.
    function automatic logic [DW_DEFAULT-1:0] sat(input logic [2*DW_DEFAULT-1:0] v);
        if (!v[2*DW_DEFAULT-1] && (|v[2*DW_DEFAULT-2:DW_DEFAULT-1]))
            return {1'b0, {(DW_DEFAULT-1){1'b1}}};
        if (v[2*DW_DEFAULT-1] && !(&v[2*DW_DEFAULT-2:DW_DEFAULT-1]))
            return {1'b1, {(DW_DEFAULT-1){1'b0}}};
        return v[DW_DEFAULT-1:0];
    endfunction

endpackage

// File: rtl/layer_weight_regfile.sv
// Weight/bias table for the layer MAC sequencer: one row of NUM_IN weights plus a
// bias per node, written only while the sequencer is idle, read combinationally.
module layer_weight_regfile
    import layer_mac_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter int NUM_NODES = 4,
    parameter int DW        = DW_DEFAULT,
    parameter int AW        = $clog2(NUM_NODES * (NUM_IN + 1)),
    parameter int NW        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    parameter int KW        = $clog2(NUM_IN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          idle,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [NW-1:0] rd_node,
    input  logic [KW-1:0] rd_k,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = NUM_NODES * (NUM_IN + 1);

    logic [DW-1:0] regs [DEPTH];

    // NOTE: the table is a bank of flops, not a RAM macro, so every entry is cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (we && idle && (int'(wr_addr) < DEPTH)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[AW'(addr(int'(rd_node), int'(rd_k), NUM_IN))];

endmodule

// File: rtl/layer_mac_sequencer.sv
// Time-multiplexes one MAC across all nodes of a fully connected layer (weighted sum, bias, ReLU).
// Define LAYER_MAC_SATURATE_EN for 2*DW signed accumulation with saturation before ReLU.
module layer_mac_sequencer
    import layer_mac_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter int NUM_NODES = 4,
    parameter int DW        = DW_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [NUM_IN*DW-1:0]                     act_in,
    input  logic                                     cfg_we,
    input  logic [$clog2(NUM_NODES*(NUM_IN+1))-1:0]  cfg_addr,
    input  logic [DW-1:0]                            cfg_wdata,
    output logic                                     busy,
    output logic                                     done,
    output logic [NUM_NODES*DW-1:0]                  node_out
);

    localparam int AW = $clog2(NUM_NODES * (NUM_IN + 1));
    localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int KW = $clog2(NUM_IN + 1);
`ifdef LAYER_MAC_SATURATE_EN
    localparam int ACC_W = 2 * DW;
`else
    localparam int ACC_W = DW;
`endif

    state_t            state, state_nxt;
    logic [NW-1:0]     node;
    logic [KW-1:0]     k;
    logic [ACC_W-1:0]  acc, prod, sum;
    logic [DW-1:0]     act_q [NUM_IN];
    logic [DW-1:0]     act_sel, tbl_data, res, relu;

    layer_weight_regfile #(
        .NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .DW(DW), .AW(AW), .NW(NW), .KW(KW)
    ) u_regfile (
        .clk(clk),
        .reset(reset),
        .we(cfg_we),
        .idle(state == IDLE),
        .wr_addr(cfg_addr),
        .wr_data(cfg_wdata),
        .rd_node(node),
        .rd_k(k),
        .rd_data(tbl_data)
    );

    // During BIAS, k == NUM_IN so the same read port returns the bias entry.
    assign act_sel = (int'(k) < NUM_IN) ? act_q[k] : '0;

`ifdef LAYER_MAC_SATURATE_EN
    assign prod = {{DW{act_sel[DW-1]}}, act_sel} * {{DW{tbl_data[DW-1]}}, tbl_data};
    assign sum  = acc + {{DW{tbl_data[DW-1]}}, tbl_data};
    assign res  = sat(sum);
`else
    assign prod = act_sel * tbl_data;
    assign sum  = acc + tbl_data;
    assign res  = sum;
`endif
    assign relu = res[DW-1] ? '0 : res;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC:  if (k == KW'(NUM_IN - 1)) state_nxt = BIAS;
            BIAS: state_nxt = (node == NW'(NUM_NODES - 1)) ? DONE : MAC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers update with <= so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            node     <= '0;
            k        <= '0;
            acc      <= '0;
            node_out <= '0;
            for (int i = 0; i < NUM_IN; i++) act_q[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < NUM_IN; i++) act_q[i] <= act_in[i*DW +: DW];
                    acc  <= '0;
                    node <= '0;
                    k    <= '0;
                end
                MAC: begin
                    acc <= acc + prod;
                    k   <= k + 1'b1;
                end
                BIAS: begin
                    node_out[int'(node)*DW +: DW] <= relu;
                    acc <= '0;
                    k   <= '0;
                    if (node != NW'(NUM_NODES - 1)) node <= node + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer: reset, evaluation/ReLU/overflow results,
// latency, busy window, start/write while busy, mid-evaluation reset, same-cycle write+start.
module tb_layer_mac_sequencer;

    localparam int NUM_IN    = 5;
    localparam int NUM_NODES = 4;
    localparam int DW        = 16;
    localparam int AW        = 5;
    localparam int LAT       = 25;

    // Slice 0 is the least significant 16 bits.
    localparam logic [NUM_IN*DW-1:0] ACT_A = {16'd0, 16'd0, 16'd1, 16'd1, 16'd0};
    localparam logic [NUM_IN*DW-1:0] ACT_B = {16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    localparam logic [NUM_IN*DW-1:0] ACT_C = {16'd0, 16'd0, 16'd0, 16'd0, 16'd100};

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [NUM_IN*DW-1:0]    act_in;
    logic                    cfg_we;
    logic [AW-1:0]           cfg_addr;
    logic [DW-1:0]           cfg_wdata;
    logic                    busy;
    logic                    done;
    logic [NUM_NODES*DW-1:0] node_out;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    layer_mac_sequencer #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .DW(DW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .act_in(act_in),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .busy(busy),
        .done(done),
        .node_out(node_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = DW'(d);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic load_table();
        write_cfg(0, -4);  write_cfg(1, 17); write_cfg(2, 26);
        write_cfg(3, -29); write_cfg(4, -17); write_cfg(5, -1);
        write_cfg(6, 1000);
        write_cfg(12, 2);  write_cfg(13, 3); write_cfg(16, 1); write_cfg(17, 5);
        write_cfg(23, 7);
    endtask

    // Starts one evaluation and watches cycles 1..30 after the start cycle.
    // At inject_cyc it raises start and a bias write and scrambles act_in for one cycle.
    task automatic run_eval(input logic [NUM_IN*DW-1:0] act, input int inject_cyc,
                            output int done_cnt, output int done_cyc, output int busy_err);
        act_in = act;
        start  = 1'b1;
        step();
        start  = 1'b0;
        cfg_we = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        busy_err = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy !== (cyc <= LAT)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == inject_cyc) begin
                start     = 1'b1;
                cfg_we    = 1'b1;
                cfg_addr  = AW'(5);
                cfg_wdata = DW'(100);
                act_in    = ~act;
            end else if (cyc == inject_cyc + 1) begin
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        act_in = '0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_mis++; $display("FAIL reset done: got %b want 0", done); end
        n_cmp++;
        if (node_out !== '0) begin n_mis++; $display("FAIL reset node_out: got %h want 0", node_out); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int dc, dy, be;
        logic [DW-1:0] exp [NUM_NODES] = '{16'd42, 16'd0, 16'd8, 16'd7};
        run_eval(ACT_A, 0, dc, dy, be);
        n_cmp++;
        if (dc != 1) begin n_mis++; $display("FAIL basic done count: got %0d want 1", dc); end
        n_cmp++;
        if (dy != LAT) begin n_mis++; $display("FAIL basic done cycle: got %0d want %0d", dy, LAT); end
        n_cmp++;
        if (be != 0) begin n_mis++; $display("FAIL basic busy window: %0d bad cycles, want 0", be); end
        for (int j = 0; j < NUM_NODES; j++) begin
            n_cmp++;
            if (node_out[j*DW +: DW] !== exp[j]) begin
                n_mis++;
                $display("FAIL basic node_out[%0d]: got %0d want %0d", j, node_out[j*DW +: DW], exp[j]);
            end
        end
    endtask

    task automatic test_relu_clamp();
        int dc, dy, be;
        logic [DW-1:0] exp [NUM_NODES] = '{16'd0, 16'd1000, 16'd11, 16'd7};
        run_eval(ACT_B, 0, dc, dy, be);
        n_cmp++;
        if (dy != LAT) begin n_mis++; $display("FAIL relu done cycle: got %0d want %0d", dy, LAT); end
        for (int j = 0; j < NUM_NODES; j++) begin
            n_cmp++;
            if (node_out[j*DW +: DW] !== exp[j]) begin
                n_mis++;
                $display("FAIL relu node_out[%0d]: got %0d want %0d", j, node_out[j*DW +: DW], exp[j]);
            end
        end
    endtask

    task automatic test_overflow();
        int dc, dy, be;
`ifdef LAYER_MAC_SATURATE_EN
        logic [DW-1:0] exp [NUM_NODES] = '{16'd0, 16'd32767, 16'd205, 16'd7};
`else
        logic [DW-1:0] exp [NUM_NODES] = '{16'd0, 16'd0, 16'd205, 16'd7};
`endif
        run_eval(ACT_C, 0, dc, dy, be);
        for (int j = 0; j < NUM_NODES; j++) begin
            n_cmp++;
            if (node_out[j*DW +: DW] !== exp[j]) begin
                n_mis++;
                $display("FAIL overflow node_out[%0d]: got %0d want %0d", j, node_out[j*DW +: DW], exp[j]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int dc, dy, be;
        logic [DW-1:0] exp [NUM_NODES] = '{16'd0, 16'd1000, 16'd11, 16'd7};
        run_eval(ACT_B, 10, dc, dy, be);
        n_cmp++;
        if (dc != 1) begin n_mis++; $display("FAIL busy-start done count: got %0d want 1", dc); end
        n_cmp++;
        if (dy != LAT) begin n_mis++; $display("FAIL busy-start done cycle: got %0d want %0d", dy, LAT); end
        n_cmp++;
        if (be != 0) begin n_mis++; $display("FAIL busy-start busy window: %0d bad cycles, want 0", be); end
        for (int j = 0; j < NUM_NODES; j++) begin
            n_cmp++;
            if (node_out[j*DW +: DW] !== exp[j]) begin
                n_mis++;
                $display("FAIL busy-start node_out[%0d]: got %0d want %0d", j, node_out[j*DW +: DW], exp[j]);
            end
        end
        // The dropped write to the node0 bias must leave it at -1.
        run_eval(ACT_A, 0, dc, dy, be);
        n_cmp++;
        if (node_out[0 +: DW] !== 16'd42) begin
            n_mis++;
            $display("FAIL busy-write dropped node_out[0]: got %0d want 42", node_out[0 +: DW]);
        end
    endtask

    task automatic test_same_cycle_write();
        int dc, dy, be;
        cfg_we    = 1'b1;
        cfg_addr  = AW'(5);
        cfg_wdata = DW'(10);
        run_eval(ACT_A, 0, dc, dy, be);
        n_cmp++;
        if (node_out[0 +: DW] !== 16'd53) begin
            n_mis++;
            $display("FAIL same-cycle write node_out[0]: got %0d want 53", node_out[0 +: DW]);
        end
        n_cmp++;
        if (dy != LAT) begin n_mis++; $display("FAIL same-cycle done cycle: got %0d want %0d", dy, LAT); end
    endtask

    task automatic test_reset_mid_eval();
        int dc, dy, be, early_done;
        logic [DW-1:0] exp [NUM_NODES] = '{16'd42, 16'd0, 16'd8, 16'd7};
        early_done = 0;
        act_in = ACT_A;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (done === 1'b1) early_done++;
            if (cyc < 12) step();
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL mid-reset busy: got %b want 0", busy); end
        n_cmp++;
        if (node_out !== '0) begin n_mis++; $display("FAIL mid-reset node_out: got %h want 0", node_out); end
        for (int c = 0; c < 3; c++) begin
            if (done === 1'b1) early_done++;
            step();
        end
        n_cmp++;
        if (early_done != 0) begin n_mis++; $display("FAIL mid-reset done pulses: got %0d want 0", early_done); end
        reset = 1'b1;
        step();
        load_table();
        run_eval(ACT_A, 0, dc, dy, be);
        n_cmp++;
        if (dy != LAT) begin n_mis++; $display("FAIL post-reset done cycle: got %0d want %0d", dy, LAT); end
        for (int j = 0; j < NUM_NODES; j++) begin
            n_cmp++;
            if (node_out[j*DW +: DW] !== exp[j]) begin
                n_mis++;
                $display("FAIL post-reset node_out[%0d]: got %0d want %0d", j, node_out[j*DW +: DW], exp[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        load_table();
        test_basic();
        test_relu_clamp();
        test_overflow();
        test_start_while_busy();
        test_same_cycle_write();
        test_reset_mid_eval();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
Time-multiplexes one 16-bit multiply-accumulate unit across all neurons of a fully connected layer, replacing per-node parallel multipliers.
- Holds a writable weight/bias table.
- On `start`, latches the layer's input activations and computes each node's weighted sum, bias and ReLU in turn.
- Publishes per-node outputs and pulses `done`.
- Sits between consecutive layer stages as the layer's compute scheduler.

Parameters:
- NUM_IN, 5, activations per node (fan-in)
- NUM_NODES, 4, neurons in the layer
- DW, 16, data width (two's complement)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request one layer evaluation; sampled only in IDLE
- act_in  in  NUM_IN*DW  activations; slice k = act_in[k*DW +: DW]; latched when start is accepted
- cfg_we  in  1  weight/bias table write enable
- cfg_addr  in  $clog2(NUM_NODES*(NUM_IN+1))  table address = node*(NUM_IN+1)+k; k==NUM_IN is the bias entry
- cfg_wdata  in  DW  table write data
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse at end of evaluation
- node_out  out  NUM_NODES*DW  node j result = node_out[j*DW +: DW]

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; busy=0; done=0; node_out=0.
  - Accumulator, activation latch, node/input counters = 0.
  - All table entries = 0.
- FSM states: IDLE, MAC, BIAS, DONE.
- IDLE:
  - start==1 latches act_in, clears acc, sets node=0, k=0, goes to MAC.
  - start==0 stays in IDLE.
- MAC (one product per cycle):
  - acc <= acc + act[k]*W[node][k].
  - k increments; after k==NUM_IN-1, go to BIAS.
- BIAS:
  - s = acc + B[node].
  - node_out[node] <= (s[DW-1]==0) ? s : 0 (ReLU).
  - Clear acc and k.
  - If node==NUM_NODES-1, go to DONE; else node++ and go to MAC.
- DONE: done=1 for exactly one cycle, busy still 1; next state IDLE.
- Latency:
  - start sampled in cycle 0; done high in cycle NUM_NODES*(NUM_IN+1)+1 (25 at defaults).
  - A new start may be sampled in the cycle after DONE.
- Arithmetic (default build):
  - Product = low DW bits of the DW x DW multiply.
  - Accumulate and bias add wrap modulo 2^DW, exactly as the existing per-node datapath.
- node_out[j] updates only in node j's BIAS cycle and otherwise holds. Outputs of unevaluated nodes keep their previous values.
- start while busy is ignored; it is not queued.
- cfg_we:
  - Commits only when state==IDLE; writes while busy are dropped.
  - Write and start in the same IDLE cycle: the write commits and the new value is used by this evaluation.
- cfg_addr >= NUM_NODES*(NUM_IN+1): write ignored.
- act_in changes during busy have no effect (the latched copy is used).
- Reset mid-evaluation: immediate return to reset state. done is not pulsed, and partial node_out values are cleared to 0.

Optional Feature:
- Macro LAYER_MAC_SATURATE_EN.
- Defined:
  - Products and accumulator are 2*DW wide and signed.
  - Bias is sign-extended.
  - Before ReLU, s is saturated to [-2^(DW-1), 2^(DW-1)-1]; node_out is therefore clamped to 0..32767.
- Undefined: wrap-around arithmetic as above, bit-exact with the existing nodes.

Decomposition:
- Package layer_mac_pkg:
  - DW default.
  - State enum {IDLE, MAC, BIAS, DONE}.
  - Table address function addr(node,k).
  - Saturation helper function.
- One sub-module: layer_weight_regfile.
  - NUM_NODES*(NUM_IN+1) x DW registers, async reset to 0.
  - Write port gated by an idle qualifier.
  - Combinational read port addressed by (node,k).

Test Plan:
- Basic evaluation:
  - Load node0 = {-4,17,26,-29,-17}, bias -1; act = {0,1,1,0,0}; start.
  - node_out[0]=42; done pulses in cycle 25; busy high cycles 1-25.
- ReLU clamp: same weights, act = {1,1,1,1,1}; sum = -8 → node_out[0]=0.
- Overflow:
  - node1 W0=1000, other weights and bias 0, act0=100 (product 100000).
  - Default build: wraps to 34464, bit15 set → node_out[1]=0.
  - With LAYER_MAC_SATURATE_EN: node_out[1]=32767.
- Start while busy:
  - Pulse start again in cycle 10 → ignored; exactly one done, in cycle 25.
  - cfg_we in cycle 10 → table unchanged.
- Reset mid-evaluation:
  - Assert reset in cycle 12 → busy=0, node_out all 0 immediately, no done.
  - Release reset and start again → correct results 25 cycles later.
- Same-cycle write and start in IDLE: the write to the node0 bias entry (address 5) is used in that evaluation, i.e. node_out[0] reflects the new bias.
